// File: rtl/s3g_tx.sv
// S3G packet transmitter: 0xD5, length, payload, CRC8 over the payload, sent byte by byte over a UART handshake.
// Optional per-byte tx_done timeout is enabled by defining S3G_TX_TIMEOUT_EN.
module s3g_tx #(
  parameter int TIMEOUT = 1000000,
  parameter int TO_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] payload_len,
  input  logic       start,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_done,
  output logic       busy,
  output logic       packet_sent,
  output logic       packet_abort
);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_LEN, S_FETCH, S_DATA, S_CRC, S_WAIT
  } state_t;

  state_t     state, state_nxt, ret;
  logic [7:0] mem [256];
  logic [7:0] rd_data;
  logic [7:0] rd_addr;
  logic [7:0] byte_cnt;
  logic [7:0] len_r;
  logic [7:0] crc;
  logic       to_hit;

  if ((64'd1 << TO_BITS) <= 64'(TIMEOUT)) begin : g_to_bits_check
    $error("TO_BITS too small to hold TIMEOUT");
  end

  // Dallas/Maxim CRC8 (reflected poly 0x8C), one byte per call
  function automatic logic [7:0] next_crc8_d8(input logic [7:0] d, input logic [7:0] c);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
    end
    return r;
  endfunction

  // Payload buffer: host writes only while idle, read data lags rd_addr by one cycle
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

`ifdef S3G_TX_TIMEOUT_EN
  logic [TO_BITS-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (tx_wr) begin
      to_cnt <= '0;
    end else if (state == S_WAIT && !tx_done) begin
      to_cnt <= to_cnt + TO_BITS'(1);
    end
  end

  assign to_hit = (state == S_WAIT) && !tx_done && (to_cnt == TO_BITS'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SOF;
      S_SOF:   state_nxt = S_WAIT;
      S_LEN:   state_nxt = S_WAIT;
      S_FETCH: state_nxt = S_DATA;
      S_DATA:  state_nxt = S_WAIT;
      S_CRC:   state_nxt = S_WAIT;
      S_WAIT: begin
        if (tx_done)     state_nxt = ret;
        else if (to_hit) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_wr   = 1'b0;
    tx_data = 8'h00;
    case (state)
      S_SOF:  begin tx_wr = 1'b1; tx_data = 8'hD5;   end
      S_LEN:  begin tx_wr = 1'b1; tx_data = len_r;   end
      S_DATA: begin tx_wr = 1'b1; tx_data = rd_data; end
      S_CRC:  begin tx_wr = 1'b1; tx_data = crc;     end
      default: ;
    endcase
  end

  // Per-packet bookkeeping and registered status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret          <= S_IDLE;
      len_r        <= 8'h00;
      byte_cnt     <= 8'h00;
      rd_addr      <= 8'h00;
      crc          <= 8'h00;
      busy         <= 1'b0;
      packet_sent  <= 1'b0;
      packet_abort <= 1'b0;
    end else begin
      packet_sent  <= 1'b0;
      packet_abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_r    <= payload_len;
            byte_cnt <= payload_len;
            crc      <= 8'h00;
            rd_addr  <= 8'h00;
            busy     <= 1'b1;
          end
        end
        S_SOF: ret <= S_LEN;
        S_LEN: ret <= (len_r == 8'd0) ? S_CRC : S_FETCH;
        S_DATA: begin
          crc      <= next_crc8_d8(rd_data, crc);
          rd_addr  <= rd_addr + 8'd1;
          byte_cnt <= byte_cnt - 8'd1;
          ret      <= (byte_cnt == 8'd1) ? S_CRC : S_FETCH;
        end
        S_CRC: ret <= S_IDLE;
        S_WAIT: begin
          if (tx_done) begin
            if (ret == S_IDLE) begin
              packet_sent <= 1'b1;
              busy        <= 1'b0;
            end
          end else if (to_hit) begin
            packet_abort <= 1'b1;
            busy         <= 1'b0;
            crc          <= 8'h00;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_s3g_tx.sv
// Directed bench for s3g_tx: a UART model answers tx_done 10 cycles after each tx_wr.
module tb_s3g_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] payload_len = 8'h00;
  logic       start = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       busy;
  logic       packet_sent;
  logic       packet_abort;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] got[$];
  int         wr_c[$];
  int         sent_cnt;
  int         abort_cnt;
  logic       sent_busy;

  always #5 clk = ~clk;

  s3g_tx #(.TIMEOUT(50), .TO_BITS(20)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .payload_len(payload_len), .start(start), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_done(tx_done), .busy(busy), .packet_sent(packet_sent), .packet_abort(packet_abort)
  );

  // Reference CRC8 (Maxim): LSB-first, feedback of the outgoing bit into 0x8C
  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[7:1]};
      if (fb) r = r ^ 8'h8C;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 8'(i);
      wr_data = base + 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_pkt(input logic [7:0] len);
    @(negedge clk);
    payload_len = len;
    start       = 1'b1;
  endtask

  // Runs a fixed number of cycles acting as the UART; optional mid-packet
  // injection of start/wr_en, async reset, or withheld tx_done (by byte count).
  task automatic run_pkt(input int budget, input int inject_idx, input int rst_idx, input int hold_idx);
    int   cd;
    logic pushed;
    cd = -1;
    got.delete();
    wr_c.delete();
    sent_cnt  = 0;
    abort_cnt = 0;
    sent_busy = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start   = 1'b0;
      wr_en   = 1'b0;
      tx_done = 1'b0;
      pushed  = 1'b0;
      if (packet_sent) begin sent_cnt++; sent_busy = busy; end
      if (packet_abort) abort_cnt++;
      if (tx_wr) begin
        got.push_back(tx_data);
        wr_c.push_back(c);
        cd     = 10;
        pushed = 1'b1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0 && !(hold_idx >= 0 && got.size() >= hold_idx)) tx_done = 1'b1;
      end
      if (pushed && got.size() == inject_idx) begin
        start       = 1'b1;
        payload_len = 8'd5;
        wr_en       = 1'b1;
        wr_addr     = 8'h00;
        wr_data     = 8'hAA;
      end
      if (pushed && got.size() == rst_idx) begin
        rst = 1'b0;
        #1;
        chk("midrst_tx_wr", 32'(tx_wr), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
    end
  endtask

  task automatic chk_pkt(input string tag, input int len, input logic [7:0] base);
    logic [7:0] exp;
    logic [7:0] c;
    c = 8'h00;
    chk({tag, "_nbytes"}, 32'(got.size()), 32'(len + 3));
    chk({tag, "_sent"}, 32'(sent_cnt), 32'd1);
    chk({tag, "_busy_at_sent"}, 32'(sent_busy), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    if (wr_c.size() > 0) chk({tag, "_first_wr"}, 32'(wr_c[0]), 32'd0);
    for (int i = 0; i < len + 3; i++) begin
      if (i == 0)             exp = 8'hD5;
      else if (i == 1)        exp = 8'(len);
      else if (i <= len + 1)  begin exp = base + 8'(i - 2); c = crc_ref(c, exp); end
      else                    exp = c;
      if (i < got.size()) chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp));
      if (i > 0 && i < wr_c.size())
        chk($sformatf("%s_gap%0d", tag, i), 32'(wr_c[i] - wr_c[i-1]),
            (i >= 2 && i <= len + 1) ? 32'd12 : 32'd11);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tx_wr", 32'(tx_wr), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_sent", 32'(packet_sent), 32'd0);
    chk("reset_abort", 32'(packet_abort), 32'd0);
    rst = 1'b1;

    // Empty packet: D5 00 00
    start_pkt(8'd0);
    run_pkt(60, -1, -1, -1);
    chk_pkt("empty", 0, 8'h00);

    // Single byte 0x01: D5 01 01 5E
    load(1, 8'h01);
    start_pkt(8'd1);
    run_pkt(80, -1, -1, -1);
    chk_pkt("single", 1, 8'h01);
    if (got.size() > 3) chk("single_crc_5e", 32'(got[3]), 32'h5E);

    // 16 bytes with a start and a buffer write injected after the first data byte
    load(16, 8'h10);
    start_pkt(8'd16);
    run_pkt(320, 3, -1, -1);
    chk_pkt("gate16", 16, 8'h10);

    // buf[0] must still hold 0x10: CRC of 0x10 is 0x9D
    start_pkt(8'd1);
    run_pkt(80, -1, -1, -1);
    chk_pkt("buf0_kept", 1, 8'h10);
    if (got.size() > 3) chk("buf0_crc_9d", 32'(got[3]), 32'h9D);

    // Async reset after the second data byte, then a clean packet
    load(4, 8'h40);
    start_pkt(8'd4);
    run_pkt(200, -1, 4, -1);
    chk("midrst_nbytes", 32'(got.size()), 32'd4);
    repeat (3) @(negedge clk);
    chk("postrst_idle_wr", 32'(tx_wr), 32'd0);
    start_pkt(8'd4);
    run_pkt(120, -1, -1, -1);
    chk_pkt("after_rst", 4, 8'h40);

    // Max length: 255 data bytes, rd_addr 0..254
    load(255, 8'h00);
    start_pkt(8'd255);
    run_pkt(3200, -1, -1, -1);
    chk_pkt("len255", 255, 8'h00);

`ifdef S3G_TX_TIMEOUT_EN
    // tx_done withheld after the LEN byte
    start_pkt(8'd2);
    run_pkt(100, -1, -1, 2);
    chk("to_abort", 32'(abort_cnt), 32'd1);
    chk("to_nbytes", 32'(got.size()), 32'd2);
    chk("to_sent", 32'(sent_cnt), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
